// File: rtl/button_repeat.sv
// button_repeat: turns a debounced button level into press/release pulses,
// typematic auto-repeat pulses, a long-press flag and a per-press repeat count.
// Every output is registered; nothing passes combinationally from input to output.
module button_repeat #(
    parameter int DELAY_CYCLES  = 25_000_000,
    parameter int REPEAT_CYCLES = 5_000_000,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int CNT_W         = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       level_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic       step_pulse,
    output logic       held,
    output logic       long_press,
    output logic [7:0] repeat_count
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(DELAY_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_PRE    = CNT_W'(LONG_CYCLES - 2);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_time;
    logic             level_prev;
    // Cleared by reset and set after the first sampled edge. level_prev resets
    // to 0, so without this a button already held through reset would look
    // like a fresh rise on the first edge; the press must be re-made instead.
    logic             armed;

    logic rise;
    logic interval_done;

    assign rise          = level_in & ~level_prev & armed;
    assign interval_done = ((state == DELAY)  && (cnt == DELAY_LAST)) ||
                           ((state == REPEAT) && (cnt == REPEAT_LAST));

    // Event FSM: press/delay/repeat sequencing, hold timer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            hold_time     <= '0;
            level_prev    <= 1'b0;
            armed         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step_pulse    <= 1'b0;
            held          <= 1'b0;
            long_press    <= 1'b0;
            repeat_count  <= '0;
        end else begin
            level_prev    <= level_in;
            armed         <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
            step_pulse    <= 1'b0;

            if (!enable) begin
                // Disabling silently drops any press in progress: no release event.
                state        <= IDLE;
                cnt          <= '0;
                hold_time    <= '0;
                held         <= 1'b0;
                long_press   <= 1'b0;
                repeat_count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state        <= DELAY;
                            cnt          <= '0;
                            hold_time    <= '0;
                            repeat_count <= '0;
                            press_pulse  <= 1'b1;
                            step_pulse   <= 1'b1;
                            held         <= 1'b1;
                        end
                    end
                    DELAY, REPEAT: begin
                        if (!level_in) begin
                            // Release wins over any repeat/long event due this edge.
                            state         <= IDLE;
                            release_pulse <= 1'b1;
                            held          <= 1'b0;
                            long_press    <= 1'b0;
                            cnt           <= '0;
                            hold_time     <= '0;
                        end else begin
                            if (hold_time != LONG_LAST)
                                hold_time <= hold_time + CNT_W'(1);
                            if (hold_time == LONG_PRE)
                                long_press <= 1'b1;
                            if (interval_done) begin
                                state        <= REPEAT;
                                cnt          <= '0;
                                repeat_pulse <= 1'b1;
                                step_pulse   <= 1'b1;
                                if (repeat_count != 8'hFF)
                                    repeat_count <= repeat_count + 8'd1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench for button_repeat: a cycle-by-cycle vector table for the
// hold/glitch/collision/enable cases plus hand-written reset and saturation runs.
module tb_button_repeat;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       level_in;
    logic       level2;
    logic       press_pulse, release_pulse, repeat_pulse, step_pulse, held, long_press;
    logic [7:0] repeat_count;
    logic       press2, release2, repeat2, step2, held2, long2;
    logic [7:0] count2;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        en;
        logic        lvl;
        logic [13:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    button_repeat #(.DELAY_CYCLES(4), .REPEAT_CYCLES(3), .LONG_CYCLES(10), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level_in(level_in),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .repeat_pulse(repeat_pulse), .step_pulse(step_pulse),
        .held(held), .long_press(long_press), .repeat_count(repeat_count)
    );

    button_repeat #(.DELAY_CYCLES(2), .REPEAT_CYCLES(2), .LONG_CYCLES(10), .CNT_W(8)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable), .level_in(level2),
        .press_pulse(press2), .release_pulse(release2),
        .repeat_pulse(repeat2), .step_pulse(step2),
        .held(held2), .long_press(long2), .repeat_count(count2)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] pk(input logic p, r, rp, st, h, lg, input int rc);
        logic [7:0] c;
        c = 8'(rc);
        return {p, r, rp, st, h, lg, c};
    endfunction

    function automatic logic [13:0] got1();
        return {press_pulse, release_pulse, repeat_pulse, step_pulse, held, long_press, repeat_count};
    endfunction

    function automatic logic [13:0] got2();
        return {press2, release2, repeat2, step2, held2, long2, count2};
    endfunction

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %b want %b (press,rel,rep,step,held,long,count[7:0])", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic row(input string name, input logic en, input logic lvl,
                       input logic p, r, rp, st, h, lg, input int rc);
        vec_t v;
        v.en = en; v.lvl = lvl; v.exp = pk(p, r, rp, st, h, lg, rc); v.name = name;
        vecs.push_back(v);
    endtask

    int pulses, bad;

    initial begin
        rst_n = 1'b0; enable = 1'b1; level_in = 1'b0; level2 = 1'b0;

        // Vector table: each row = inputs held across one edge, expected outputs after it.
        //          name      en lvl p  r  rp st h  lg rc
        row("idle",      1, 0, 0, 0, 0, 0, 0, 0, 0);
        row("hold_E0",   1, 1, 1, 0, 0, 1, 1, 0, 0);
        row("hold_E1",   1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("hold_E2",   1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("hold_E3",   1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("hold_E4",   1, 1, 0, 0, 1, 1, 1, 0, 1);
        row("hold_E5",   1, 1, 0, 0, 0, 0, 1, 0, 1);
        row("hold_E6",   1, 1, 0, 0, 0, 0, 1, 0, 1);
        row("hold_E7",   1, 1, 0, 0, 1, 1, 1, 0, 2);
        row("hold_E8",   1, 1, 0, 0, 0, 0, 1, 0, 2);
        row("hold_E9",   1, 1, 0, 0, 0, 0, 1, 1, 2);
        row("hold_E10",  1, 1, 0, 0, 1, 1, 1, 1, 3);
        row("hold_E11",  1, 1, 0, 0, 0, 0, 1, 1, 3);
        row("hold_E12",  1, 1, 0, 0, 0, 0, 1, 1, 3);
        row("hold_E13",  1, 1, 0, 0, 1, 1, 1, 1, 4);
        row("hold_E14",  1, 0, 0, 1, 0, 0, 0, 0, 4);
        row("hold_E15",  1, 0, 0, 0, 0, 0, 0, 0, 4);
        row("glitch_E0", 1, 1, 1, 0, 0, 1, 1, 0, 0);
        row("glitch_E1", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        row("glitch_E2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row("coll_E0",   1, 1, 1, 0, 0, 1, 1, 0, 0);
        row("coll_E1",   1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("coll_E2",   1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("coll_E3",   1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("coll_E4",   1, 0, 0, 1, 0, 0, 0, 0, 0);
        row("coll_E5",   1, 0, 0, 0, 0, 0, 0, 0, 0);
        row("en_E0",     1, 1, 1, 0, 0, 1, 1, 0, 0);
        row("en_E1",     1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("en_E2",     1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("en_E3",     1, 1, 0, 0, 0, 0, 1, 0, 0);
        row("en_E4",     1, 1, 0, 0, 1, 1, 1, 0, 1);
        row("en_E5_off", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        row("en_E6_off", 0, 1, 0, 0, 0, 0, 0, 0, 0);
        row("en_E7_on",  1, 1, 0, 0, 0, 0, 0, 0, 0);
        row("en_E8_on",  1, 1, 0, 0, 0, 0, 0, 0, 0);
        row("en_E9_low", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        row("en_E10_re", 1, 1, 1, 0, 0, 1, 1, 0, 0);
        row("en_E11",    1, 0, 0, 1, 0, 0, 0, 0, 0);
        row("en_E12",    1, 0, 0, 0, 0, 0, 0, 0, 0);

        #2;
        check("reset_state", got1(), pk(0, 0, 0, 0, 0, 0, 0));
        tick();
        check("reset_held_clk", got1(), pk(0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            enable   = vecs[i].en;
            level_in = vecs[i].lvl;
            tick();
            check(vecs[i].name, got1(), vecs[i].exp);
        end

        // Reset mid-hold: reach REPEAT, then assert reset asynchronously.
        enable = 1'b1;
        level_in = 1'b1;
        tick();
        check("rst_E0_press", got1(), pk(1, 0, 0, 1, 1, 0, 0));
        repeat (6) tick();
        check("rst_E6_repeat", got1(), pk(0, 0, 0, 0, 1, 0, 1));
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", got1(), pk(0, 0, 0, 0, 0, 0, 0));
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_no_press_%0d", i), got1(), pk(0, 0, 0, 0, 0, 0, 0));
        end
        level_in = 1'b0;
        tick();
        check("rst_low", got1(), pk(0, 0, 0, 0, 0, 0, 0));
        level_in = 1'b1;
        tick();
        check("rst_new_press", got1(), pk(1, 0, 0, 1, 1, 0, 0));
        level_in = 1'b0;
        tick();
        check("rst_release", got1(), pk(0, 1, 0, 0, 0, 0, 0));

        // Saturation on the fast instance: repeats every 2 edges, count stops at 255.
        level2 = 1'b1;
        tick();
        check("sat_E0_press", got2(), pk(1, 0, 0, 1, 1, 0, 0));
        pulses = 0;
        bad = 0;
        for (int i = 1; i < 600; i++) begin
            tick();
            if (repeat2) pulses++;
            if (repeat2 !== (i % 2 == 0) || step2 !== (i % 2 == 0) || press2 !== 1'b0) bad++;
            if (i == 8)   check_int("sat_long_E8", int'(long2), 0);
            if (i == 9)   check_int("sat_long_E9", int'(long2), 1);
            if (i == 508) check_int("sat_count_E508", int'(count2), 254);
            if (i == 510) check_int("sat_count_E510", int'(count2), 255);
        end
        check_int("sat_pulse_pattern_errors", bad, 0);
        check_int("sat_pulse_total", pulses, 299);
        check_int("sat_count_final", int'(count2), 255);
        level2 = 1'b0;
        tick();
        check("sat_release", got2(), pk(0, 1, 0, 0, 0, 0, 255));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
